// File: rtl/systolic_tile_ctrl.sv
// Tile sequencer for an ARR_N x ARR_N output-stationary systolic array.
// Walks the (m,n,k) tiles through load, compute and write-back phases.
module systolic_tile_ctrl #(
  parameter int ARR_N  = 4,
  parameter int M_SIZE = 8,
  parameter int N_SIZE = 8,
  parameter int K_SIZE = 16,
  localparam int TM   = (M_SIZE + ARR_N - 1) / ARR_N,
  localparam int TN   = (N_SIZE + ARR_N - 1) / ARR_N,
  localparam int TK   = (K_SIZE + ARR_N - 1) / ARR_N,
  localparam int MX_A = (TM > TN) ? TM : TN,
  localparam int MX_B = (MX_A > TK) ? MX_A : TK,
  localparam int MX_C = (MX_B > 3 * ARR_N) ? MX_B : 3 * ARR_N,
  localparam int CW   = $clog2(MX_C + 1),
  localparam int RW   = $clog2(ARR_N),
  localparam int PW   = 2 * ARR_N - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             data_valid,
  input  logic             wr_ready,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [CW-1:0]    tile_m,
  output logic [CW-1:0]    tile_n,
  output logic [CW-1:0]    tile_k,
  output logic [ARR_N-1:0] valid_a,
  output logic [ARR_N-1:0] valid_b,
  output logic             acc_clr,
  output logic [PW-1:0]    path_en,
  output logic             wr_en,
  output logic [RW-1:0]    wr_row
);

  localparam int NB = ARR_N * ARR_N;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] B_LAST  = BW'(NB - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(3 * ARR_N - 1);
  localparam logic [CW-1:0] TM_LAST = CW'(TM - 1);
  localparam logic [CW-1:0] TN_LAST = CW'(TN - 1);
  localparam logic [CW-1:0] TK_LAST = CW'(TK - 1);
  localparam logic [RW-1:0] R_LAST  = RW'(ARR_N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, WRITE} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [CW-1:0] c_q, c_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] tm_q, tm_d, tn_q, tn_d, tk_q, tk_d;
  logic          done_d;
  logic          beat_acc;
  logic [ARR_N-1:0] va_d;
  logic [PW-1:0]    pe_d;

  assign beat_acc = (state_q == LOAD) && data_valid;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    c_d     = c_q;
    row_d   = row_q;
    tm_d    = tm_q;
    tn_d    = tn_q;
    tk_d    = tk_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          b_d     = '0;
          tm_d    = '0;
          tn_d    = '0;
          tk_d    = '0;
        end
      end
      LOAD: begin
        if (beat_acc) begin
          if (b_q == B_LAST) begin
            state_d = COMPUTE;
            b_d     = '0;
            c_d     = '0;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        if (c_q == C_LAST) begin
          c_d = '0;
          if (tk_q != TK_LAST) begin
            tk_d    = tk_q + 1'b1;
            state_d = LOAD;
          end else begin
            tk_d    = '0;
            row_d   = '0;
            state_d = WRITE;
          end
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          if (row_q == R_LAST) begin
            row_d = '0;
            if (tn_q != TN_LAST) begin
              tn_d    = tn_q + 1'b1;
              state_d = LOAD;
            end else begin
              tn_d = '0;
              if (tm_q != TM_LAST) begin
                tm_d    = tm_q + 1'b1;
                state_d = LOAD;
              end else begin
                tm_d    = '0;
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The pulse for the final load beat lands in the first compute cycle and is
  // merged with the compute skew window there.
  always_comb begin
    va_d = '0;
    pe_d = '0;
    for (int r = 0; r < ARR_N; r++) begin
      if (beat_acc && (int'(b_q) / ARR_N) == r) va_d[r] = 1'b1;
      if (state_d == COMPUTE && int'(c_d) >= r && int'(c_d) < r + ARR_N) va_d[r] = 1'b1;
    end
    for (int p = 0; p < PW; p++) begin
      if (state_d == COMPUTE && int'(c_d) >= p + 1 && int'(c_d) <= p + ARR_N) pe_d[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      c_q     <= '0;
      row_q   <= '0;
      tm_q    <= '0;
      tn_q    <= '0;
      tk_q    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      valid_a <= '0;
      valid_b <= '0;
      acc_clr <= 1'b0;
      path_en <= '0;
      wr_en   <= 1'b0;
      wr_row  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      c_q     <= c_d;
      row_q   <= row_d;
      tm_q    <= tm_d;
      tn_q    <= tn_d;
      tk_q    <= tk_d;
      busy    <= (state_d != IDLE);
      done    <= done_d;
      rd_en   <= (state_d == LOAD);
      valid_a <= va_d;
      valid_b <= va_d;
      acc_clr <= (state_d == COMPUTE) && (c_d == '0) && (tk_d == '0);
      path_en <= pe_d;
      wr_en   <= (state_d == WRITE);
      wr_row  <= row_d;
    end
  end

  assign tile_m = tm_q;
  assign tile_n = tn_q;
  assign tile_k = tk_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Bench for systolic_tile_ctrl at default parameters (4x4 array, 8x8x16 job).
// Expected write-phase tile order is queued at job start and popped per phase.
module tb_systolic_tile_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       data_valid = 1'b1;
  logic       wr_ready = 1'b1;
  logic       busy, done, rd_en, acc_clr, wr_en;
  logic [3:0] tile_m, tile_n, tile_k;
  logic [3:0] valid_a, valid_b;
  logic [6:0] path_en;
  logic [1:0] wr_row;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  systolic_tile_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_valid(data_valid),
    .wr_ready(wr_ready), .busy(busy), .done(done), .rd_en(rd_en),
    .tile_m(tile_m), .tile_n(tile_n), .tile_k(tile_k),
    .valid_a(valid_a), .valid_b(valid_b), .acc_clr(acc_clr),
    .path_en(path_en), .wr_en(wr_en), .wr_row(wr_row)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {30'd0, busy, done, rd_en, tile_m, tile_n, tile_k, valid_a, valid_b,
            acc_clr, path_en, wr_en, wr_row};
  endfunction

  task automatic run_job(input int ld_stall, input int wr_stall, input bit hold_start,
                         input int exp_busy);
    int busy_cyc = 0, wbeats = 0, va_ones = 0, pe_ones = 0, clr_n = 0;
    int ld_beats = 0, cc = -1, ld_left = 0, wr_left = 0, mism_ab = 0, extra = 0;
    bit ld_done = 0, wr_done = 0, fin = 0;
    int t;
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 2; n++) exp_q.push_back(m * 16 + n);
    data_valid = 1'b1;
    wr_ready   = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("tiles_at_start", {tile_m, tile_n, tile_k}, 0);
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (busy) busy_cyc++;
      va_ones += $countones(valid_a);
      pe_ones += $countones(path_en);
      if (valid_a !== valid_b) mism_ab++;
      if (acc_clr) clr_n++;
      if (acc_clr && clr_n == 1) cc = 0;
      if (cc >= 0) begin
        chk("path_en0_win", path_en[0], (cc >= 1 && cc <= 4));
        chk("path_en6_win", path_en[6], (cc >= 7 && cc <= 10));
        cc = (cc == 11) ? -1 : cc + 1;
      end
      if (ld_left > 0) begin
        chk("rd_en_stall", rd_en, 1);
        chk("valid_a_stall", valid_a, 0);
        ld_left--;
        if (ld_left == 0) data_valid = 1'b1;
      end else if (ld_stall >= 0 && !ld_done && rd_en && ld_beats == ld_stall) begin
        data_valid = 1'b0;
        ld_left    = 5;
        ld_done    = 1;
      end
      if (rd_en && data_valid) ld_beats++;
      if (wr_left > 0) begin
        chk("wr_en_stall", wr_en, 1);
        chk("wr_row_stall", wr_row, wr_stall);
        wr_left--;
        if (wr_left == 0) wr_ready = 1'b1;
      end else if (wr_stall >= 0 && !wr_done && wr_en && wr_row == wr_stall) begin
        wr_ready = 1'b0;
        wr_left  = 3;
        wr_done  = 1;
      end
      if (wr_en && wr_ready) begin
        chk("wr_row_seq", wr_row, wbeats % 4);
        if (wbeats % 4 == 0) begin
          if (exp_q.size() == 0) chk("tile_order_underflow", 1, 0);
          else begin
            t = exp_q.pop_front();
            chk("tile_order", tile_m * 16 + tile_n, t);
            chk("tile_k_in_write", tile_k, 0);
          end
        end
        wbeats++;
      end
      if (done) begin
        chk("busy_at_done", busy, 0);
        if (hold_start) start = 1'b0;
        fin = 1;
      end
      @(negedge clk);
    end
    if (!fin) chk("job_timeout", 0, 1);
    for (int i = 0; i < 5; i++) begin
      if (done || busy) extra++;
      @(negedge clk);
    end
    chk("idle_after_done", extra, 0);
    chk("busy_cycles", busy_cyc, exp_busy);
    chk("write_beats", wbeats, 16);
    chk("valid_a_ones", va_ones, 512);
    chk("path_en_ones", pe_ones, 448);
    chk("acc_clr_count", clr_n, 4);
    chk("valid_ab_equal", mism_ab, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_job();
    int seen_done = 0;
    bit fin = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      if (done) seen_done++;
      if (acc_clr && tile_m == 1 && tile_n == 0) fin = 1;
      else @(negedge clk);
    end
    if (!fin) chk("rst_wait_timeout", 0, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    #1 chk("rst_async_outs", all_outs(), 0);
    @(posedge clk);
    #1 chk("rst_edge_outs", all_outs(), 0);
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("no_done_on_abort", seen_done + done, 0);
    chk("idle_after_abort", busy, 0);
  endtask

  initial begin
    #1 chk("reset_outs", all_outs(), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", all_outs(), 0);
    run_job(-1, -1, 1'b0, 464);
    run_job(7, -1, 1'b0, 469);
    run_job(-1, 2, 1'b0, 467);
    reset_mid_job();
    run_job(-1, -1, 1'b0, 464);
    run_job(-1, -1, 1'b1, 464);
    run_job(-1, -1, 1'b0, 464);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_tile_ctrl.md
SYSTOLIC_TILE_CTRL -- requirements
Module: systolic_tile_ctrl

Interface
REQ-001 Parameter ARR_N, 4, systolic array edge (N x N PEs), range 2..16.
REQ-002 Parameter M_SIZE, 8, output rows of the full matrix product.
REQ-003 Parameter N_SIZE, 8, output columns of the full matrix product.
REQ-004 Parameter K_SIZE, 16, reduction depth.
REQ-005 Derived constants: TM=ceil(M_SIZE/ARR_N), TN=ceil(N_SIZE/ARR_N), TK=ceil(K_SIZE/ARR_N), CW=clog2(max(TM,TN,TK,3*ARR_N)+1).
REQ-006 clk  in  1  clock; all flops rise-edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  job request, sampled only in IDLE.
REQ-009 data_valid  in  1  operand buffer has the current load beat.
REQ-010 wr_ready  in  1  result sink accepts the current write beat.
REQ-011 busy  out  1  high from the cycle after start is accepted until the job ends.
REQ-012 done  out  1  one-cycle pulse at job end.
REQ-013 rd_en  out  1  operand read request.
REQ-014 tile_m, tile_n, tile_k  out  CW each  current tile indices.
REQ-015 valid_a, valid_b  out  ARR_N each  per-row/column operand valid into the array.
REQ-016 acc_clr  out  1  clear PE accumulators.
REQ-017 path_en  out  2*ARR_N-1  diagonal result-path register enables.
REQ-018 wr_en  out  1  result write beat valid.
REQ-019 wr_row  out  clog2(ARR_N)  result row index of the current write beat.

Function
REQ-020 FSM states: IDLE, LOAD, COMPUTE, WRITE; all outputs registered.
REQ-021 IDLE: start=1 -> LOAD next cycle, busy=1, tile_m=tile_n=tile_k=0; start while busy ignored.
REQ-022 LOAD: beat counter b runs 0..ARR_N*ARR_N-1; rd_en=1 while b<ARR_N*ARR_N; b advances only on rd_en&data_valid (stall otherwise, all outputs held).
REQ-023 LOAD: valid_a[r]=valid_b[r]=1 for exactly one cycle after each accepted beat with b/ARR_N==r; otherwise 0.
REQ-024 LOAD -> COMPUTE in the cycle after the last beat is accepted; b cleared.
REQ-025 COMPUTE: counter c runs 0..3*ARR_N-1, no stall; valid_a[r]=valid_b[r]=(r<=c<r+ARR_N).
REQ-026 COMPUTE: path_en[p]=(p+1<=c<=p+ARR_N) for p=0..2*ARR_N-2.
REQ-027 acc_clr=1 only for c==0 when tile_k==0.
REQ-028 End of COMPUTE: tile_k<TK-1 -> tile_k+1, LOAD; else tile_k=0, WRITE.
REQ-029 WRITE: wr_en=1, wr_row steps 0..ARR_N-1, advancing only on wr_en&wr_ready; wr_en, wr_row held while wr_ready=0.
REQ-030 After the last accepted write beat: tile_n+1 (wrap to 0 at TN, then tile_m+1); if tile_m wrapped at TM -> IDLE with done=1 and busy=0 in the same cycle; else LOAD.
REQ-031 Non-multiple sizes use the ceiling tile count; padding of partial tiles is external.
REQ-032 TM=TN=TK=1: exactly one LOAD, one COMPUTE, one WRITE.

Reset
REQ-033 rst_n=0 at any time forces IDLE, counters and tile indices 0, all outputs 0; an in-flight job is discarded and done is not asserted.
REQ-034 First start after reset release is accepted normally.

Verification
REQ-035 Defaults, data_valid=wr_ready=1, start pulse -> busy high exactly 16*(16+12)+4*4=464 cycles, one done pulse, 4 write phases, tile order (m,n)=(0,0),(0,1),(1,0),(1,1).
REQ-036 data_valid low 5 cycles at LOAD beat 7 -> rd_en held, b frozen at 7, busy extended by 5 cycles, no lost or duplicated valid_a pulse.
REQ-037 wr_ready low 3 cycles at wr_row=2 -> wr_en=1, wr_row=2 held 3 cycles; then 3 completes the phase.
REQ-038 COMPUTE, ARR_N=4 -> path_en[0] high c=1..4, path_en[6] high c=7..10; acc_clr once per output tile (4 total).
REQ-039 rst_n low mid-COMPUTE of tile (1,0) -> all outputs 0 next edge, no done; a new start runs the full 464-cycle job.
REQ-040 start held high through the whole job -> exactly one job and one done; a second job is accepted only from IDLE.
